// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch sequencer.
// It requests one word from instruction memory at the current pc and holds
// the word for decode until it is accepted. It then advances pc, either
// sequentially or by a redirect, and requests the next word.
// Optional macro FETCH_BUBBLE_EN adds a one-cycle BUBBLE state after every
// redirect. During that cycle flush is high and the new pc is already visible.
module fetch_unit (
  input  logic        CLK,
  input  logic        RST,
  output logic [15:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] instr,
  output logic [4:0]  opcode,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        pcSrc,
  input  logic        C_offset,
  input  logic [15:0] branch_target,
  input  logic [15:0] offset,
  output logic [15:0] pc,
  output logic        flush
);

  localparam logic [4:0] NOP_OPCODE = 5'b00111;

`ifdef FETCH_BUBBLE_EN
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ISSUE, S_BUBBLE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ISSUE} state_t;
`endif

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;

  // Relative redirect target. Two's-complement addition truncated to 16 bits
  // wraps modulo 2^16.
  logic signed [15:0] offset_s;
  logic signed [15:0] pc_rel;
  assign offset_s = signed'(offset);
  assign pc_rel   = signed'(pc_q) + offset_s;

  // State, pc and instruction register; asynchronous reset to the idle state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      pc_q    <= 16'h0000;
      instr_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Next-state logic: the fetch handshake, accept, and pc update.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        // Memory responses are taken only here; acks in other states are dropped.
        if (imem_ack) begin
          instr_d = imem_data;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Redirect inputs are looked at only on the accept cycle.
        if (!stall) begin
          state_d = S_REQ;
          if (!pcSrc) begin
            pc_d = pc_q + 16'd1;
          end else begin
            if (C_offset) pc_d = unsigned'(pc_rel);
            else          pc_d = branch_target;
`ifdef FETCH_BUBBLE_EN
            state_d = S_BUBBLE;
`endif
          end
        end
      end
`ifdef FETCH_BUBBLE_EN
      S_BUBBLE: state_d = S_REQ;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode straight from registered state, so reset clears them at once.
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign imem_req    = (state_q == S_REQ);
  assign instr_valid = (state_q == S_ISSUE);
  assign opcode      = instr_valid ? instr_q[31:27] : NOP_OPCODE;
`ifdef FETCH_BUBBLE_EN
  assign flush       = (state_q == S_BUBBLE);
`else
  assign flush       = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus randomized transactions.
// Expectations come from a pc model, and a monitor checks them against a scoreboard.
module tb_fetch_unit;

`ifdef FETCH_BUBBLE_EN
  localparam bit BUB = 1'b1;
`else
  localparam bit BUB = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic [4:0]  opcode;
  logic        instr_valid;
  logic        stall;
  logic        pcSrc;
  logic        C_offset;
  logic [15:0] branch_target;
  logic [15:0] offset;
  logic [15:0] pc;
  logic        flush;

  fetch_unit dut (
    .CLK(CLK), .RST(RST), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_ack(imem_ack), .imem_data(imem_data), .instr(instr), .opcode(opcode),
    .instr_valid(instr_valid), .stall(stall), .pcSrc(pcSrc), .C_offset(C_offset),
    .branch_target(branch_target), .offset(offset), .pc(pc), .flush(flush)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] data;
    logic [15:0] pc;
  } issue_t;

  issue_t      issue_q[$];
  logic [15:0] fetch_q[$];
  logic [15:0] model_pc;
  int          checks = 0;
  int          errors = 0;
  bit          done   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard queues.
  always @(negedge CLK) begin
    if (!done) begin
      chk("addr_is_pc", imem_addr, pc);
      if (!instr_valid) chk("nop_opcode", opcode, 5'b00111);
      if (!BUB) chk("flush_tied_low", flush, 1'b0);
      if (imem_req && imem_ack) begin
        if (fetch_q.size() == 0) chk("unexpected_fetch", imem_addr, 32'hDEAD);
        else chk("fetch_addr", imem_addr, fetch_q.pop_front());
      end
      if (instr_valid) begin
        if (issue_q.size() == 0) begin
          chk("unexpected_issue", instr, 32'hDEAD_BEEF);
        end else begin
          chk("issue_instr", instr, issue_q[0].data);
          chk("issue_opcode", opcode, issue_q[0].data[31:27]);
          chk("issue_pc", pc, issue_q[0].pc);
          if (!stall) void'(issue_q.pop_front());
        end
      end
    end
  end

  // One complete transaction: wait for the request, answer it, stall, then accept.
  task automatic do_fetch(input logic [31:0] data, input int ack_delay, input int stalls,
                          input logic ps, input logic coff,
                          input logic [15:0] tgt, input logic [15:0] off);
    int n = 0;
    while (!imem_req && n < 20) begin
      stall = 1'($urandom);
      tick();
      n++;
    end
    if (!imem_req) begin
      chk("req_timeout", imem_req, 1'b1);
      return;
    end
    for (int i = 0; i < ack_delay; i++) begin
      stall = 1'($urandom);
      tick();
    end
    imem_ack  = 1'b1;
    imem_data = data;
    fetch_q.push_back(model_pc);
    issue_q.push_back('{data: data, pc: model_pc});
    tick();
    imem_ack  = 1'b0;
    imem_data = $urandom;
    chk("valid_after_ack", instr_valid, 1'b1);
    for (int i = 0; i < stalls; i++) begin
      stall         = 1'b1;
      pcSrc         = 1'($urandom);
      C_offset      = 1'($urandom);
      branch_target = 16'($urandom);
      offset        = 16'($urandom);
      imem_ack      = 1'($urandom);
      tick();
    end
    stall         = 1'b0;
    imem_ack      = 1'b0;
    pcSrc         = ps;
    C_offset      = coff;
    branch_target = tgt;
    offset        = off;
    tick();
    if (!ps)       model_pc = model_pc + 16'd1;
    else if (coff) model_pc = model_pc + off;
    else           model_pc = tgt;
    chk("pc_after_accept", pc, model_pc);
    chk("flush_after_accept", flush, BUB && ps);
    chk("req_after_accept", imem_req, !(BUB && ps));
    pcSrc         = 1'($urandom);
    C_offset      = 1'($urandom);
    branch_target = 16'($urandom);
    offset        = 16'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; imem_ack = 1'b0; imem_data = '0; stall = 1'b0; pcSrc = 1'b0;
    C_offset = 1'b0; branch_target = '0; offset = '0; model_pc = 16'h0000;
    #12;
    chk("rst_pc", pc, 16'h0000);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_flush", flush, 1'b0);
    chk("rst_opcode", opcode, 5'b00111);
    @(negedge CLK);
    RST = 1'b0;

    // First fetch after reset: address 0, ack in the third cycle.
    do_fetch(32'h1000_0000, 1, 0, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("first_pc", pc, 16'h0001);

    // Long stall with noise on pcSrc and imem_ack, then a sequential accept.
    do_fetch(32'h5A5A_1234, 0, 4, 1'b0, 1'b0, 16'h0, 16'h0);

    // Redirects: absolute, relative with a negative offset, absolute again.
    do_fetch(32'h2222_0000, 0, 0, 1'b1, 1'b0, 16'h0010, 16'h0);
    do_fetch(32'h3333_0000, 2, 1, 1'b1, 1'b1, 16'h7777, 16'hFFFC);
    chk("rel_target", pc, 16'h000C);
    do_fetch(32'h4444_0000, 0, 0, 1'b1, 1'b0, 16'h0ABC, 16'h0);
    chk("abs_target", pc, 16'h0ABC);

    // Sequential fetch across the top of the address space.
    do_fetch(32'h5555_0000, 0, 0, 1'b1, 1'b0, 16'hFFFF, 16'h0);
    do_fetch(32'h6666_0000, 1, 0, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("wrap_pc", pc, 16'h0000);
    do_fetch(32'h7777_0000, 0, 0, 1'b0, 1'b0, 16'h0, 16'h0);

    // Reset in the middle of a request, and a response that arrives too late.
    begin
      int n = 0;
      while (!imem_req && n < 20) begin tick(); n++; end
    end
    #2 RST = 1'b1;
    #1;
    chk("midreq_req", imem_req, 1'b0);
    chk("midreq_pc", pc, 16'h0000);
    chk("midreq_instr", instr, 32'h0);
    chk("midreq_opcode", opcode, 5'b00111);
    model_pc = 16'h0000;
    @(negedge CLK);
    RST = 1'b0;
    imem_ack = 1'b1;
    imem_data = 32'hFFFF_FFFF;
    tick();
    imem_ack = 1'b0;
    chk("late_ack_instr", instr, 32'h0);
    chk("late_ack_valid", instr_valid, 1'b0);
    chk("restart_req", imem_req, 1'b1);
    chk("restart_addr", imem_addr, 16'h0000);
    do_fetch(32'h8888_0001, 0, 0, 1'b0, 1'b0, 16'h0, 16'h0);

    // Randomized transactions.
    for (int t = 0; t < 60; t++) begin
      logic ps;
      ps = ($urandom_range(0, 2) == 0);
      do_fetch($urandom, $urandom_range(0, 3), $urandom_range(0, 3), ps,
               1'($urandom), 16'($urandom), 16'($urandom));
    end

    tick();
    tick();
    chk("issue_queue_drained", issue_q.size(), 0);
    chk("fetch_queue_drained", fetch_q.size(), 0);
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 CLK  in  1  system clock; all state SHALL change on rising edge only, except reset.
REQ-002 RST  in  1  reset; SHALL be asynchronous and active-high.
REQ-003 imem_addr  out  16  instruction memory word address; SHALL equal pc.
REQ-004 imem_req  out  1  fetch request; high in REQ state only.
REQ-005 imem_ack  in  1  memory response strobe; imem_data valid in the same cycle.
REQ-006 imem_data  in  32  fetched instruction word.
REQ-007 instr  out  32  instruction register.
REQ-008 opcode  out  5  decode opcode to control unit: instr[31:27] when instr_valid=1, else 5'b00111 (P-type nop).
REQ-009 instr_valid  out  1  instr/opcode valid for decode.
REQ-010 stall  in  1  downstream hold; instruction not consumed while high.
REQ-011 pcSrc  in  1  redirect request from control unit.
REQ-012 C_offset  in  1  redirect mode: 0 = absolute target, 1 = pc-relative.
REQ-013 branch_target  in  16  absolute jump target.
REQ-014 offset  in  16  signed two's-complement relative offset.
REQ-015 pc  out  16  current program counter.
REQ-016 flush  out  1  one-cycle pulse in BUBBLE state; low when FETCH_BUBBLE_EN is undefined.

Function
REQ-017 States SHALL be IDLE, REQ, ISSUE, plus BUBBLE when FETCH_BUBBLE_EN is defined.
REQ-018 IDLE: all outputs at reset values; unconditional transition to REQ next cycle.
REQ-019 REQ: imem_req=1; on imem_ack=1, instr <= imem_data and go to ISSUE; otherwise stay in REQ with imem_addr stable.
REQ-020 Latency: ack sampled at edge N -> instr_valid=1 after edge N; minimum throughput one instruction per 2 cycles.
REQ-021 ISSUE: instr_valid=1; stall=1 holds instr, pc, and state unchanged.
REQ-022 Accept = ISSUE & stall=0; at accept, pc updates and state goes to REQ.
REQ-023 Accept with pcSrc=0: pc <= pc+1.
REQ-024 Accept with pcSrc=1, C_offset=0: pc <= branch_target.
REQ-025 Accept with pcSrc=1, C_offset=1: pc <= pc+offset (signed).
REQ-026 All pc arithmetic SHALL be modulo 2^16; 0xFFFF+1 wraps to 0x0000; no overflow flag.
REQ-027 pcSrc, C_offset, branch_target, and offset SHALL be ignored outside accept.
REQ-028 imem_ack outside REQ SHALL be ignored and SHALL NOT modify instr.
REQ-029 stall outside ISSUE SHALL have no effect.

Reset
REQ-030 RST=1 SHALL immediately force state IDLE, pc=0x0000, instr=0, instr_valid=0, imem_req=0, flush=0, and opcode=5'b00111, regardless of CLK.
REQ-031 Reset mid-REQ SHALL drop imem_req combinationally with RST; a response arriving after RST SHALL be discarded in IDLE.
REQ-032 The first request after RST falls SHALL use imem_addr=0x0000.

Configuration
REQ-033 Macro FETCH_BUBBLE_EN, defined: an accept with pcSrc=1 goes to BUBBLE (instr_valid=0, opcode=5'b00111, flush=1) for exactly one cycle, then REQ; the new pc is already visible during BUBBLE.
REQ-034 Macro FETCH_BUBBLE_EN, undefined: no BUBBLE state; a redirect accept goes directly to REQ; flush is tied to 0.

Verification
REQ-035 Reset then ack at 3rd cycle with imem_data=0x1000_0000 -> imem_addr=0x0000 during wait; next cycle instr_valid=1, opcode=5'b00010; after accept, pc=0x0001.
REQ-036 ISSUE with stall=1 for 4 cycles, toggling pcSrc and imem_ack -> instr, pc, and opcode constant; on stall=0 with pcSrc=0, pc increments by exactly 1.
REQ-037 pc=0x0010, accept with pcSrc=1, C_offset=1, offset=0xFFFC -> pc=0x000C; with C_offset=0, branch_target=0x0ABC -> pc=0x0ABC; with FETCH_BUBBLE_EN defined, flush=1 for one cycle, then imem_req=1.
REQ-038 pc=0xFFFF, sequential accept -> pc=0x0000 and next imem_addr=0x0000.
REQ-039 Assert RST mid-REQ, then present ack one cycle after RST release -> instr stays 0; REQ restarts at address 0x0000.
